// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI transfer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int CHAR_LEN_W = 7;
    localparam int MAX_BITS   = 128;
    localparam int BITS_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // A char_len of zero encodes the longest transfer.
    function automatic logic [BITS_W-1:0] char_len_to_bits(input logic [CHAR_LEN_W-1:0] len);
        return (len == '0) ? BITS_W'(MAX_BITS) : {1'b0, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_clkgen
//  Description : Programmable SCLK divider. Flags the leading/trailing edge
//                combinationally in the cycle the sclk register will toggle.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             cpol_i,
    output logic             sclk_o,
    output logic             tick_o,
    output logic             lead_o,
    output logic             trail_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    // Terminal count toggles sclk; while disabled sclk parks at the idle level.
    always_comb begin
        tick_o  = en_i && (cnt_q == div_i);
        lead_o  = tick_o && (sclk_q == cpol_i);
        trail_o = tick_o && (sclk_q != cpol_i);
        cnt_d   = '0;
        sclk_d  = cpol_i;
        if (en_i) begin
            cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
            sclk_d = tick_o ? ~sclk_q : sclk_q;
        end
    end

    // Divider counter and sclk register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_ctrl
//  Description : SPI master transfer sequencer: latches configuration, drives
//                SCLK, shift-register strobes, slave selects, done and irq.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int SS_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go_i,
    input  logic [CHAR_LEN_W-1:0] char_len_i,
    input  logic [DIV_W-1:0]      divider_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  ass_i,
    input  logic [SS_W-1:0]       ss_in_i,
    input  logic                  ie_i,
    input  logic                  irq_clr_i,
    output logic                  busy_o,
    output logic                  load_tx_o,
    output logic                  tx_shift_o,
    output logic                  rx_sample_o,
    output logic                  sclk_o,
    output logic [SS_W-1:0]       ss_n_o,
    output logic                  done_o,
    output logic                  irq_o,
    output logic [BITS_W-1:0]     bits_left_o
);

    state_e            state_q, state_d;
    logic [BITS_W-1:0] n_q, n_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [BITS_W-1:0] tog_q, tog_d;
    logic [BITS_W-1:0] bits_q, bits_d;
    logic              busy_q, busy_d;
    logic              load_q, load_d;
    logic              tx_q, tx_d;
    logic              rx_q, rx_d;
    logic              done_q, done_d;
    logic              irq_q, irq_d;
    logic [SS_W-1:0]   ss_n_q, ss_n_d;

    logic              w_cpol_eff;
    logic              w_tick, w_lead, w_trail;
    logic              w_go_acc;
    logic [BITS_W:0]   w_last_idx;
    logic              w_last_tog;

    // sclk tracks the live polarity while idle, the latched one otherwise.
    assign w_cpol_eff = (state_q == ST_IDLE) ? cpol_i : cpol_q;
    // Toggle index 2N-1 is the final edge; 9 bits keep N=128 representable.
    assign w_last_idx = {n_q, 1'b0} - 9'd1;
    assign w_last_tog = ({1'b0, tog_q} == w_last_idx);

    spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q == ST_RUN),
        .div_i   (div_q),
        .cpol_i  (w_cpol_eff),
        .sclk_o  (sclk_o),
        .tick_o  (w_tick),
        .lead_o  (w_lead),
        .trail_o (w_trail)
    );

    // Next-state logic, configuration latch and registered-output decode.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        div_d    = div_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        tog_d    = tog_q;
        bits_d   = rx_q ? bits_q - 8'd1 : bits_q;
        irq_d    = irq_q;
        w_go_acc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go_i) begin
                    w_go_acc = 1'b1;
                    state_d  = ST_LOAD;
                    n_d      = char_len_to_bits(char_len_i);
                    bits_d   = char_len_to_bits(char_len_i);
                    div_d    = divider_i;
                    cpol_d   = cpol_i;
                    cpha_d   = cpha_i;
                    tog_d    = '0;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (w_tick) begin
                    tog_d = tog_q + 8'd1;
                    if (w_last_tog) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        load_d = (state_d == ST_LOAD);
        done_d = (state_d == ST_DONE);
        rx_d   = (state_q == ST_RUN) && (cpha_q ? w_trail : w_lead);
        // cpha=0 presents bit 1 ahead of the first edge, so the final
        // trailing edge has nothing left to shift.
        tx_d   = ((state_q == ST_LOAD) && !cpha_q) ||
                 ((state_q == ST_RUN) && (cpha_q ? w_lead : (w_trail && !w_last_tog)));
        ss_n_d = ~(ss_in_i & (ass_i ? {SS_W{busy_d}} : {SS_W{1'b1}}));

        if ((state_q == ST_DONE) && ie_i) irq_d = 1'b1;
        else if (irq_clr_i || w_go_acc)   irq_d = 1'b0;
    end

    // State, latched configuration and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            div_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            tog_q   <= '0;
            bits_q  <= '0;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            tx_q    <= 1'b0;
            rx_q    <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            ss_n_q  <= '1;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            div_q   <= div_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            tog_q   <= tog_d;
            bits_q  <= bits_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
            ss_n_q  <= ss_n_d;
        end
    end

    assign busy_o      = busy_q;
    assign load_tx_o   = load_q;
    assign tx_shift_o  = tx_q;
    assign rx_sample_o = rx_q;
    assign done_o      = done_q;
    assign irq_o       = irq_q;
    assign ss_n_o      = ss_n_q;
    assign bits_left_o = bits_q;

endmodule
`default_nettype wire
